// File: rtl/bconv_sched.sv
// Round-robin job scheduler for a shared fastBConv datapath: two requesters, one
// residue vector per cycle from the source buffer, write-back as results emerge.
module bconv_sched #(
    parameter int RNS_PRIME_BITS = 8,
    parameter int W              = RNS_PRIME_BITS,
    parameter int N_IN           = 4,
    parameter int N_OUT          = 4,
    parameter int N_COEFF        = 16,
    parameter int AW             = $clog2(N_COEFF),
    parameter int LW             = $clog2(N_COEFF + 1),
    parameter int DP_LAT         = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  req_valid,
    input  logic [LW-1:0]               req_len0,
    input  logic [LW-1:0]               req_len1,
    output logic [1:0]                  req_ack,
    output logic                        rd_en,
    output logic                        rd_sel,
    output logic [AW-1:0]               rd_addr,
    input  logic [N_IN-1:0][W-1:0]      rd_data,
    output logic                        dp_in_valid,
    output logic [N_IN-1:0][W-1:0]      dp_x,
    input  logic                        dp_out_valid,
    input  logic [N_OUT-1:0][W-1:0]     dp_c,
    output logic                        wr_en,
    output logic                        wr_sel,
    output logic [AW-1:0]               wr_addr,
    output logic [N_OUT-1:0][W-1:0]     wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        done_id
);

    if (DP_LAT < 1) begin : g_bad_lat
        $error("bconv_sched: DP_LAT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic            cur_id_q, cur_id_d;
    logic            last_q, last_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [LW-1:0]   wr_cnt_q, wr_cnt_d;
    logic            dp_vld_q;

    // Grant: lone requester wins, a tie goes to whoever was not served last.
    logic            gnt_any, gnt_id;
    logic [LW-1:0]   req_len_g, len_clip;

    assign gnt_any   = |req_valid;
    assign gnt_id    = (&req_valid) ? ~last_q : req_valid[1];
    assign req_len_g = gnt_id ? req_len1 : req_len0;
    assign len_clip  = (req_len_g > LW'(N_COEFF)) ? LW'(N_COEFF) : req_len_g;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_id_q    <= 1'b0;
            last_q      <= 1'b1;
            len_q       <= '0;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            dp_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            last_q      <= last_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            dp_vld_q    <= rd_en;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        last_d      = last_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        wr_cnt_d    = wr_en ? wr_cnt_q + LW'(1) : wr_cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    cur_id_d    = gnt_id;
                    len_d       = len_clip;
                    issue_cnt_d = '0;
                    wr_cnt_d    = '0;
                    state_d     = (len_clip != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                issue_cnt_d = issue_cnt_q + LW'(1);
                if (issue_cnt_q == len_q - LW'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (wr_en && (wr_cnt_q == len_q - LW'(1))) state_d = DONE;
            end
            DONE: begin
                last_d  = cur_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        req_ack     = '0;
        if (state_q == IDLE && gnt_any) req_ack = gnt_id ? 2'b10 : 2'b01;
        rd_en       = (state_q == ISSUE);
        rd_sel      = rd_en & cur_id_q;
        rd_addr     = rd_en ? issue_cnt_q[AW-1:0] : '0;
        dp_in_valid = dp_vld_q;
        dp_x        = rd_data;
        // Results arriving while idle belong to an aborted job and are dropped.
        wr_en       = dp_out_valid & busy;
        wr_sel      = wr_en & cur_id_q;
        wr_addr     = wr_en ? wr_cnt_q[AW-1:0] : '0;
        wr_data     = dp_c;
        done        = (state_q == DONE);
        done_id     = done & cur_id_q;
    end

endmodule
